branch_resolve_unit: RTL and testbench

//  Parametrised branch-condition and target resolver for the ID/EX boundary. It supersedes the

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond_eval.sv | 38 +++
 rtl/branch_resolve_unit.sv | 112 +++++++++++
 tb/tb_branch_resolve_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
//   cond_t  : 3-bit branch condition codes COND_EQ..COND_LT
//   stage_t : occupancy of the single-entry result stage
package branch_pkg;

    typedef enum logic [2:0] {
        COND_EQ  = 3'd0,  // a == b
        COND_NE  = 3'd1,  // a != b
        COND_LEZ = 3'd2,  // a <= 0 (signed)
        COND_GTZ = 3'd3,  // a >  0 (signed)
        COND_LTZ = 3'd4,  // a <  0 (signed)
        COND_GEZ = 3'd5,  // a >= 0 (signed)
        COND_LTU = 3'd6,  // a <  b (unsigned)
        COND_LT  = 3'd7   // a <  b (signed)
    } cond_t;

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   cond   in  3      condition code (branch_pkg::cond_t)
//   data_a in  WIDTH  rs operand
//   data_b in  WIDTH  rt operand (EQ/NE/LTU/LT only)
//   taken  out 1      condition holds
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             taken
);

    logic a_neg;
    logic a_zero;

    always_comb begin
        a_neg  = data_a[WIDTH-1];
        a_zero = (data_a == '0);
        taken  = 1'b0;
        case (cond_t'(cond))
            COND_EQ:  taken = (data_a == data_b);
            COND_NE:  taken = (data_a != data_b);
            COND_LEZ: taken = a_neg || a_zero;
            COND_GTZ: taken = !a_neg && !a_zero;
            COND_LTZ: taken = a_neg;
            COND_GEZ: taken = !a_neg;
            COND_LTU: taken = (data_a < data_b);
            COND_LT:  taken = ($signed(data_a) < $signed(data_b));
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch condition and target resolver at the ID/EX boundary.
// Resolves one branch per accepted request into a registered single-entry
// result stage with valid/ready handshake, flush and saturating statistics.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake from decode
//   cond, data_a, data_b     condition code and operands
//   pc, offset               branch PC and signed word offset
//   flush                    kill held result, block acceptance this cycle
//   out_valid / out_ready    result handshake to PC-select
//   out_taken, out_target    resolved direction and next PC
//   taken_cnt, total_cnt     consumed taken / consumed total (saturating)
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFF_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [OFF_W-1:0] offset,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [WIDTH-1:0] out_target,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    stage_t           state;
    stage_t           state_next;
    logic             load;
    logic             consume;
    logic             cond_taken;
    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] target;

    branch_cond_eval #(
        .WIDTH (WIDTH)
    ) u_cond_eval (
        .cond   (cond),
        .data_a (data_a),
        .data_b (data_b),
        .taken  (cond_taken)
    );

    // Size cast of a signed value sign-extends; wrap-around is intentional.
    always_comb begin
        off_ext = WIDTH'($signed(offset));
        pc_seq  = pc + WIDTH'(4);
        target  = cond_taken ? (pc_seq + (off_ext << 2)) : pc_seq;
    end

    assign out_valid = (state == STAGE_FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign load      = in_valid && in_ready;
    // Flush outranks a consume in the same cycle.
    assign consume   = out_valid && out_ready && !flush;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = STAGE_EMPTY;
        end else if (load) begin
            state_next = STAGE_FULL;
        end else if (consume) begin
            state_next = STAGE_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STAGE_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_taken  <= 1'b0;
            out_target <= '0;
        end else if (load) begin
            out_taken  <= cond_taken;
            out_target <= target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt <= '0;
            total_cnt <= '0;
        end else if (consume) begin
            if (total_cnt != '1) begin
                total_cnt <= total_cnt + CNT_W'(1);
            end
            if (out_taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cond;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] pc;
    logic [15:0] offset;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic [15:0] taken_cnt;
    logic [15:0] total_cnt;

    // Second instance with 2-bit counters for saturation.
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_taken;
    logic [31:0] s_out_target;
    logic [1:0]  s_taken_cnt;
    logic [1:0]  s_total_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(32), .OFF_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .data_a(data_a), .data_b(data_b), .pc(pc), .offset(offset),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target),
        .taken_cnt(taken_cnt), .total_cnt(total_cnt)
    );

    branch_resolve_unit #(.WIDTH(32), .OFF_W(16), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .cond(cond), .data_a(data_a), .data_b(data_b), .pc(pc), .offset(offset),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_taken(s_out_taken), .out_target(s_out_target),
        .taken_cnt(s_taken_cnt), .total_cnt(s_total_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for direction and target, in plain arithmetic.
    function automatic bit ref_taken(input int c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (c)
            0: return ua == ub;
            1: return ua != ub;
            2: return sa <= 0;
            3: return sa > 0;
            4: return sa < 0;
            5: return sa >= 0;
            6: return ua < ub;
            default: return sa < sb;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input bit t, input logic [31:0] p, input logic [15:0] o);
        longint nxt;
        nxt = longint'(p) + 4;
        if (t) nxt = nxt + longint'($signed(o)) * 4;
        return nxt[31:0];
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural model: one-entry result slot plus unbounded event counts.
    bit          m_valid;
    bit          m_taken;
    logic [31:0] m_target;
    longint      m_total;
    longint      m_ntaken;
    bit          exp_ready;

    always_comb exp_ready = !flush && (!m_valid || out_ready);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_taken  <= 1'b0;
            m_target <= '0;
            m_total  <= 0;
            m_ntaken <= 0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else begin
            if (m_valid && out_ready) begin
                m_total  <= m_total + 1;
                m_ntaken <= m_ntaken + (m_taken ? 1 : 0);
            end
            if (in_valid && exp_ready) begin
                m_valid  <= 1'b1;
                m_taken  <= ref_taken(int'(cond), data_a, data_b);
                m_target <= ref_target(ref_taken(int'(cond), data_a, data_b), pc, offset);
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("out_taken", out_taken, m_taken);
                check("out_target", out_target, m_target);
            end
            check("total_cnt", total_cnt, sat(m_total, 65535));
            check("taken_cnt", taken_cnt, sat(m_ntaken, 65535));
            check("s_total_cnt", s_total_cnt, sat(m_total, 3));
            check("s_taken_cnt", s_taken_cnt, sat(m_ntaken, 3));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit v, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [15:0] o);
        in_valid = v;
        cond     = c;
        data_a   = a;
        data_b   = b;
        pc       = p;
        offset   = o;
    endtask

    initial begin
        logic [7:0]  exp_cond;
        logic [31:0] held_target;
        exp_cond = 8'b1001_0110;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        req(1'b0, 3'd0, '0, '0, '0, '0);
        step(); step();
        #2 rst = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_target", out_target, 32'h0);

        // Condition set with a=-1, b=1, back-to-back.
        out_ready = 1'b1;
        for (int unsigned c = 0; c < 8; c++) begin
            req(1'b1, 3'(c), 32'hFFFF_FFFF, 32'h1, 32'h0, 16'h0);
            step();
            check($sformatf("cond%0d", c), out_taken, exp_cond[c]);
        end

        // Targets.
        req(1'b1, 3'd0, 32'h5, 32'h5, 32'h100, 16'hFFFF);
        step();
        check("tgt_taken_back", out_target, 32'h100);
        req(1'b1, 3'd1, 32'h5, 32'h5, 32'h100, 16'hFFFF);
        step();
        check("tgt_not_taken", out_target, 32'h104);
        req(1'b1, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 16'h1);
        step();
        check("tgt_wrap", out_target, 32'h4);
        req(1'b0, 3'd0, '0, '0, '0, '0);
        step();

        // Backpressure from a clean count.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        out_ready = 1'b0;
        req(1'b1, 3'd0, 32'h7, 32'h7, 32'h2000, 16'h0010);
        step();
        held_target = out_target;
        check("bp_target", held_target, 32'h2044);
        for (int unsigned i = 0; i < 5; i++) begin
            req(1'b1, 3'd1, 32'(i), 32'(i), 32'h3000 + 32'(i * 4), 16'h0);
            check("bp_in_ready", in_ready, 1'b0);
            step();
            check("bp_hold", out_target, held_target);
        end
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            req(1'b1, 3'(i), 32'h0, 32'h1, 32'h4000 + 32'(i * 16), 16'h2);
            step();
            check("stream_valid", out_valid, 1'b1);
        end
        req(1'b0, 3'd0, '0, '0, '0, '0);
        step();
        check("stream_total", total_cnt, 16'd5);

        // Flush with a held result and a ready consumer.
        out_ready = 1'b0;
        req(1'b1, 3'd0, 32'h1, 32'h1, 32'h500, 16'h1);
        step();
        out_ready = 1'b1;
        flush = 1'b1;
        req(1'b1, 3'd0, 32'h1, 32'h1, 32'h600, 16'h1);
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0;
        req(1'b0, 3'd0, '0, '0, '0, '0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_total", total_cnt, 16'd5);

        // Reset mid-handshake.
        out_ready = 1'b0;
        req(1'b1, 3'd0, 32'h2, 32'h2, 32'h700, 16'h3);
        step();
        req(1'b0, 3'd0, '0, '0, '0, '0);
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_taken", out_taken, 1'b0);
        check("arst_target", out_target, 32'h0);
        check("arst_total", total_cnt, 16'd0);
        check("arst_tcnt", taken_cnt, 16'd0);
        step();
        #2 rst = 1'b0;
        step();
        check("post_rst_ready", in_ready, 1'b1);

        // Saturation with 2-bit counters.
        out_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            req(1'b1, 3'd4, 32'h8000_0000, 32'h0, 32'h100 * 32'(i), 16'h1);
            step();
        end
        req(1'b0, 3'd0, '0, '0, '0, '0);
        step();
        check("sat_taken", s_taken_cnt, 2'd3);
        check("sat_total", s_total_cnt, 2'd3);
        check("wide_taken", taken_cnt, 16'd5);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
